mrd_factor_gen: RTL and testbench
=================================

# mrd_factor_gen

Upstream parameter generator for the mixed-radix DFT controller. On each `sink_sop` it latches `dftpts` and iteratively factors the size into radix stages in the fixed order 4, 2, 5, 3. It then derives the per-stage twiddle denominators, the radix-2 stage index, and the `dftpts_div_base`/`factor_5` pair. All results are committed atomically to registered outputs that `mrd_ctrl_fsm` consumes in place of its hard-coded constants.

## Interface
Parameters:
- `NSTG`, 6, number of stage slots
- `W_PTS`, 12, width of DFT size

Ports:
- `clk`, in, 1, sole clock
- `rst_n`, in, 1, asynchronous active-low reset
- `sink_sop`, in, 1, start-of-packet; `dftpts` is valid in the same cycle
- `dftpts`, in, 12, DFT size N
- `busy`, out, 1, high from the cycle after `sink_sop` through the DONE cycle
- `param_valid`, out, 1, one-cycle pulse; all outputs below are updated in that same cycle
- `Nf`, out, [0:5][2:0], stage factors (4, 2, 5, 3, or 1 for unused slots)
- `NumOfFactors`, out, 3, count of `Nf` entries ≠ 1
- `stage_of_rdx2`, out, 3, index of the factor-2 stage; 7 if there is none
- `twdl_demontr`, out, [0:5][11:0], value of N before stage j is divided out
- `dftpts_div_base`, out, 12, N/15 if `factor_5`, else N/3
- `factor_5`, out, 1, 5 divides N
- `size_err`, out, 1, N cannot be represented as a valid factorization

## Operation
- FSM states: IDLE → FACT (6 cycles, slot counter j=0..5) → DIV3 → DIV5 → DONE → IDLE.
- IDLE, `sink_sop`=1:
  - load working residual R=`dftpts`, set j=0, clear the shadow registers, go to FACT.
- FACT, per cycle:
  - shadow `twdl[j]`=R.
  - Pick f by priority: 4 if R[1:0]==0; else 2 if R[0]==0; else 5 if `div5_ok`; else 3 if `div3_ok`; else 1.
  - If R==1, f=1.
  - Update R=R/f. Division by 4 or 2 is a shift; division by 5 or 3 uses the quotient from the sub-module.
  - shadow `Nf[j]`=f.
  - If f≠1, increment the factor count.
  - If f==2, record `rdx2`=j. The 4-before-2 priority means at most one 2 occurs.
  - j==5 → DIV3.
- DIV3:
  - `err`=(R≠1) | (N==0) | !`div3_ok`(N).
  - B=N/3.
- DIV5:
  - `f5`=any shadow `Nf`==5.
  - If `f5`, B=B/5; else B is held.
- DONE: copy all shadow values to the outputs and pulse `param_valid`.
- Divide-by-constant arithmetic:
  - q3=(x·5462)>>14 and q5=(x·3277)>>14, with a 25-bit product.
  - Exact flags: `div3_ok`=(3·q3==x), `div5_ok`=(5·q5==x), both computed with shift-add.
  - The quotient is exact for all 12-bit multiples.
- On error, the outputs still commit. Nf/twdl hold the partial factorization, `size_err`=1, and `dftpts_div_base`=0.

## Timing
- Reset: all outputs 0, except `stage_of_rdx2`=7 and `Nf`=all 1. FSM returns to IDLE.
- Reset asserted mid-computation aborts the run and produces no `param_valid`.
- Fixed latency: `sink_sop` sampled at edge t gives `param_valid`=1 in cycle t+9. DIV5 always takes one cycle, so latency does not depend on `factor_5`.
- Outputs hold their previous values during `busy` and change only in the `param_valid` cycle.
- `sink_sop` while `busy`: restart immediately with the new `dftpts` and discard the old run. Latency is t+9 from the new sop.
- `sink_sop` in the DONE cycle: the commit completes and the new run starts next cycle.
- Back-to-back sops (every cycle) keep `busy`=1 and never pulse `param_valid`.

## Structure
- Package `mrd_pkg`:
  - `NSTG`=6 and `RDX2_NONE`=3'd7
  - reciprocal constants `RCP3`=5462, `RCP5`=3277, `RCP_SH`=14
  - FSM state enum
  - factor-code localparams
- Sub-module `mrd_div_const`: purely combinational; input x[11:0]; outputs q3, q5, `div3_ok`, `div5_ok`. It is instantiated twice: once for R in FACT and once for B/N in the DIV states (one shared instance with a mux is also acceptable).

## Test plan
- sop, N=1200 → t+9:
  - Nf={4,4,5,5,3,1}, NumOfFactors=5, stage_of_rdx2=7, twdl={1200,300,75,15,3,1}
  - factor_5=1, base=80, size_err=0
- N=1152 → Nf={4,4,4,2,3,3}, NumOfFactors=6, stage_of_rdx2=3, twdl={1152,288,72,18,9,3}, factor_5=0, base=384.
- N=12 → Nf={4,3,1,1,1,1}, NumOfFactors=2, twdl={12,3,1,1,1,1}, base=4.
- N=84 (contains 7) → size_err=1, base=0, Nf={4,3,1,1,1,1}. N=0 → size_err=1.
- sop N=1200, then sop N=1152 at t+4 → exactly one `param_valid`, at (t+4)+9, carrying the 1152 results.
- Reset pulse at t+5 of a 1200 run → no `param_valid`; outputs return to reset values; a later sop completes normally.

Source files
------------

// File: rtl/mrd_pkg.sv
// rtl/mrd_pkg.sv - shared constants, factor codes and FSM states for the factor generator
package mrd_pkg;

  localparam int NSTG = 6;
  localparam logic [2:0] RDX2_NONE = 3'd7;

  // Reciprocal multipliers for exact divide-by-3 / divide-by-5 on 12-bit operands
  localparam int RCP3   = 5462;
  localparam int RCP5   = 3277;
  localparam int RCP_SH = 14;

  // Stage factor codes
  localparam logic [2:0] FC_1 = 3'd1;
  localparam logic [2:0] FC_2 = 3'd2;
  localparam logic [2:0] FC_3 = 3'd3;
  localparam logic [2:0] FC_4 = 3'd4;
  localparam logic [2:0] FC_5 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FACT,
    S_DIV3,
    S_DIV5,
    S_DONE
  } state_t;

endpackage

// File: rtl/mrd_div_const.sv
// rtl/mrd_div_const.sv - combinational divide-by-3 and divide-by-5 with exactness flags
module mrd_div_const
  import mrd_pkg::*;
(
  input  logic [11:0] x,
  output logic [11:0] q3,
  output logic [11:0] q5,
  output logic        div3_ok,
  output logic        div5_ok
);

  logic [24:0] p3;
  logic [24:0] p5;
  logic [13:0] m3;
  logic [13:0] m5;

  assign p3 = 25'(x) * 25'(RCP3);
  assign p5 = 25'(x) * 25'(RCP5);
  assign q3 = 12'(p3 >> RCP_SH);
  assign q5 = 12'(p5 >> RCP_SH);

  // Multiply the quotient back with shift-add; equality means x was an exact multiple
  assign m3 = {1'b0, q3, 1'b0} + {2'b00, q3};
  assign m5 = {q5, 2'b00} + {2'b00, q5};
  assign div3_ok = (m3 == {2'b00, x});
  assign div5_ok = (m5 == {2'b00, x});

endmodule

// File: rtl/mrd_factor_gen.sv
// rtl/mrd_factor_gen.sv - factors the DFT size into 4/2/5/3 stages and commits stage parameters
module mrd_factor_gen #(
  parameter int NSTG  = 6,
  parameter int W_PTS = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sink_sop,
  input  logic [W_PTS-1:0]               dftpts,
  output logic                           busy,
  output logic                           param_valid,
  output logic [0:NSTG-1][2:0]           Nf,
  output logic [2:0]                     NumOfFactors,
  output logic [2:0]                     stage_of_rdx2,
  output logic [0:NSTG-1][W_PTS-1:0]     twdl_demontr,
  output logic [W_PTS-1:0]               dftpts_div_base,
  output logic                           factor_5,
  output logic                           size_err
);

  import mrd_pkg::*;

  state_t                      state;
  logic [W_PTS-1:0]            n_lat;
  logic [W_PTS-1:0]            r;
  logic [W_PTS-1:0]            b;
  logic [2:0]                  j;
  logic [2:0]                  cnt;
  logic [2:0]                  rdx2;
  logic                        err;
  logic                        f5;
  logic [0:NSTG-1][2:0]        sh_nf;
  logic [0:NSTG-1][W_PTS-1:0]  sh_tw;

  logic [W_PTS-1:0]            dx;
  logic [W_PTS-1:0]            dq3;
  logic [W_PTS-1:0]            dq5;
  logic                        dok3;
  logic                        dok5;
  logic [2:0]                  f;
  logic [W_PTS-1:0]            r_div;
  logic                        any5;

  assign busy = (state != S_IDLE);

  // One shared divider: residual during FACT, latched N in DIV3, base in DIV5
  always_comb begin
    dx = n_lat;
    if (state == S_FACT)      dx = r;
    else if (state == S_DIV5) dx = b;
  end

  mrd_div_const u_div (
    .x       (dx),
    .q3      (dq3),
    .q5      (dq5),
    .div3_ok (dok3),
    .div5_ok (dok5)
  );

  // Factor choice for the current residual; 4 outranks 2 so at most one radix-2 stage appears
  always_comb begin
    f     = FC_1;
    r_div = r;
    if (r == W_PTS'(1)) begin
      f     = FC_1;
      r_div = r;
    end else if (r[1:0] == 2'b00) begin
      f     = FC_4;
      r_div = r >> 2;
    end else if (!r[0]) begin
      f     = FC_2;
      r_div = r >> 1;
    end else if (dok5) begin
      f     = FC_5;
      r_div = dq5;
    end else if (dok3) begin
      f     = FC_3;
      r_div = dq3;
    end
  end

  // Whether any chosen stage is radix-5
  always_comb begin
    any5 = 1'b0;
    for (int i = 0; i < NSTG; i++) begin
      if (sh_nf[i] == FC_5) any5 = 1'b1;
    end
  end

  // Sequencer: a new sop always restarts; the DONE cycle commits shadows to the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      n_lat           <= '0;
      r               <= '0;
      b               <= '0;
      j               <= '0;
      cnt             <= '0;
      rdx2            <= RDX2_NONE;
      err             <= 1'b0;
      f5              <= 1'b0;
      sh_nf           <= {NSTG{FC_1}};
      sh_tw           <= '0;
      param_valid     <= 1'b0;
      Nf              <= {NSTG{FC_1}};
      NumOfFactors    <= '0;
      stage_of_rdx2   <= RDX2_NONE;
      twdl_demontr    <= '0;
      dftpts_div_base <= '0;
      factor_5        <= 1'b0;
      size_err        <= 1'b0;
    end else begin
      param_valid <= 1'b0;
      if (state == S_DONE) begin
        param_valid     <= 1'b1;
        Nf              <= sh_nf;
        NumOfFactors    <= cnt;
        stage_of_rdx2   <= rdx2;
        twdl_demontr    <= sh_tw;
        dftpts_div_base <= err ? '0 : b;
        factor_5        <= f5;
        size_err        <= err;
      end
      if (sink_sop) begin
        state <= S_FACT;
        n_lat <= dftpts;
        r     <= dftpts;
        b     <= '0;
        j     <= '0;
        cnt   <= '0;
        rdx2  <= RDX2_NONE;
        err   <= 1'b0;
        f5    <= 1'b0;
        sh_nf <= {NSTG{FC_1}};
        sh_tw <= '0;
      end else begin
        case (state)
          S_FACT: begin
            sh_tw[j] <= r;
            sh_nf[j] <= f;
            r        <= r_div;
            if (f != FC_1) cnt <= cnt + 3'd1;
            if (f == FC_2) rdx2 <= j;
            if (j == 3'(NSTG - 1)) state <= S_DIV3;
            else                   j     <= j + 3'd1;
          end
          S_DIV3: begin
            err   <= (r != W_PTS'(1)) | (n_lat == '0) | !dok3;
            b     <= dq3;
            state <= S_DIV5;
          end
          S_DIV5: begin
            f5    <= any5;
            if (any5) b <= dq5;
            state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mrd_factor_gen.sv
// tb/tb_mrd_factor_gen.sv - scoreboard bench for mrd_factor_gen with a reference factorization model
module tb_mrd_factor_gen;

  typedef struct packed {
    logic [0:5][2:0]  nf;
    logic [2:0]       cnt;
    logic [2:0]       rdx2;
    logic [0:5][11:0] tw;
    logic [11:0]      base;
    logic             f5;
    logic             err;
  } res_t;

  typedef struct {
    int   due;
    res_t r;
  } pend_t;

  logic              clk;
  logic              rst_n;
  logic              sink_sop;
  logic [11:0]       dftpts;
  logic              busy;
  logic              param_valid;
  logic [0:5][2:0]   Nf;
  logic [2:0]        NumOfFactors;
  logic [2:0]        stage_of_rdx2;
  logic [0:5][11:0]  twdl_demontr;
  logic [11:0]       dftpts_div_base;
  logic              factor_5;
  logic              size_err;

  mrd_factor_gen #(.NSTG(6), .W_PTS(12)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sink_sop        (sink_sop),
    .dftpts          (dftpts),
    .busy            (busy),
    .param_valid     (param_valid),
    .Nf              (Nf),
    .NumOfFactors    (NumOfFactors),
    .stage_of_rdx2   (stage_of_rdx2),
    .twdl_demontr    (twdl_demontr),
    .dftpts_div_base (dftpts_div_base),
    .factor_5        (factor_5),
    .size_err        (size_err)
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  bit    mon_en = 0;
  pend_t q[$];
  res_t  held;
  res_t  rst_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: repeated trial division in the fixed 4,2,5,3 priority order
  function automatic res_t model(input int n);
    res_t e;
    int   r;
    int   f;
    e.nf   = {6{3'd1}};
    e.tw   = '0;
    e.cnt  = 3'd0;
    e.rdx2 = 3'd7;
    e.f5   = 1'b0;
    r = n;
    for (int k = 0; k < 6; k++) begin
      e.tw[k] = 12'(r);
      if (r == 1)          f = 1;
      else if (r % 4 == 0) f = 4;
      else if (r % 2 == 0) f = 2;
      else if (r % 5 == 0) f = 5;
      else if (r % 3 == 0) f = 3;
      else                 f = 1;
      e.nf[k] = 3'(f);
      r = r / f;
      if (f != 1) e.cnt = e.cnt + 3'd1;
      if (f == 2) e.rdx2 = 3'(k);
      if (f == 5) e.f5 = 1'b1;
    end
    e.err  = (r != 1) || (n == 0) || (n % 3 != 0);
    e.base = e.err ? 12'd0 : 12'(e.f5 ? n / 15 : n / 3);
    return e;
  endfunction

  task automatic check_res(input string name, input res_t got, input res_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  // Monitor: compares strobe, busy and all result outputs against the scoreboard each cycle
  always @(negedge clk) begin
    if (mon_en) begin
      res_t got;
      bit   exp_pv;
      bit   exp_busy;
      got      = {Nf, NumOfFactors, stage_of_rdx2, twdl_demontr, dftpts_div_base, factor_5, size_err};
      exp_pv   = (q.size() > 0) && (q[0].due == cyc);
      exp_busy = (q.size() > 0) && (q[q.size()-1].due > cyc);
      check_bit("param_valid", param_valid, exp_pv);
      check_bit("busy", busy, exp_busy);
      if (exp_pv) begin
        check_res("result", got, q[0].r);
        held = q[0].r;
        void'(q.pop_front());
      end else begin
        check_res("hold", got, held);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Drive one sop; runs still pending at the sampling edge are abandoned by the DUT
  task automatic issue(input int n);
    pend_t p;
    sink_sop = 1'b1;
    dftpts   = 12'(n);
    @(posedge clk);
    #2;
    while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
    p.due = cyc + 9;
    p.r   = model(n);
    q.push_back(p);
    sink_sop = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    held = rst_val;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic int valid_n();
    int n;
    int f;
    n = 3;
    for (int k = 0; k < 5; k++) begin
      f = $urandom_range(1, 5);
      if (n * f <= 4095) n = n * f;
    end
    return n;
  endfunction

  initial begin
    rst_val.nf   = {6{3'd1}};
    rst_val.cnt  = 3'd0;
    rst_val.rdx2 = 3'd7;
    rst_val.tw   = '0;
    rst_val.base = 12'd0;
    rst_val.f5   = 1'b0;
    rst_val.err  = 1'b0;
    held     = rst_val;
    rst_n    = 1'b1;
    sink_sop = 1'b0;
    dftpts   = 12'd0;
    #1;
    rst_n  = 1'b0;
    mon_en = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    issue(1200); idle(12);
    issue(1152); idle(12);
    issue(12);   idle(12);
    issue(84);   idle(12);
    issue(0);    idle(12);
    issue(1);    idle(12);
    issue(3);    idle(12);
    issue(4095); idle(12);
    issue(2187); idle(12);

    issue(1200); idle(3);
    issue(1152); idle(12);

    issue(1200); idle(4);
    do_reset();  idle(3);
    issue(1152); idle(12);

    issue(12);   idle(8);
    issue(1200); idle(12);

    for (int i = 0; i < 20; i++) issue($urandom_range(0, 4095));
    idle(12);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) issue(valid_n());
      else                           issue($urandom_range(0, 4095));
      idle($urandom_range(0, 11));
    end
    idle(12);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
